shift_sequencer: RTL and testbench

- Command-driven controller for the 8-bit bidirectional shift register.
- Drives the register's mode select, serial input and parallel-load bus.
- Accepts one command at a time over a valid/ready handshake. A command is an optional parallel load followed by N shifts in one direction.
- Streams the bits shifted out, then pulses done. Sits between a host/bus-side engine and the shift-register datapath.

---
 rtl/shift_sequencer_if.sv | 43 ++++
 rtl/shift_sequencer.sv | 99 +++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Command and datapath signals of the shift sequencer, bundled with host (master) and controller (slave) views.
// Under SHIFT_SEQ_ROTATE_EN the bundle also carries cmd_rot.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             cmd_rot;
`endif
  logic             sin;
  logic [1:0]       sr_s;
  logic             sr_r;
  logic [WIDTH-1:0] sr_i;
  logic [WIDTH-1:0] sr_q;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_load, cmd_dir, cmd_len, cmd_data,
`ifdef SHIFT_SEQ_ROTATE_EN
    output cmd_rot,
`endif
    output sin, sr_q,
    input  cmd_ready, sr_s, sr_r, sr_i, sout, sout_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_dir, cmd_len, cmd_data,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  cmd_rot,
`endif
    input  sin, sr_q,
    output cmd_ready, sr_s, sr_r, sr_i, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command sequencer for a WIDTH-bit bidirectional shift register: optional load, then N shifts, then a done pulse.
// Optional SHIFT_SEQ_ROTATE_EN adds cmd_rot, feeding sout back into sr_r to rotate the register.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave io
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic [1:0]       sr_s_q;
  logic             busy_q, done_q, ready_q, shift_q;
  logic [CNT_W-1:0] len_clamp;
  logic             cmd_rot_w;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign cmd_rot_w = io.cmd_rot;
`else
  assign cmd_rot_w = 1'b0;
`endif

  assign len_clamp = (io.cmd_len > LEN_MAX) ? LEN_MAX : io.cmd_len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: if (io.cmd_valid) begin
        data_d = io.cmd_data;
        dir_d  = io.cmd_dir;
        rot_d  = cmd_rot_w;
        cnt_d  = len_clamp;
        if (io.cmd_load)           state_d = LOAD;
        else if (len_clamp != '0)  state_d = SHIFT;
        else                       state_d = DONE;
      end
      LOAD:  state_d = (cnt_q != '0) ? SHIFT : DONE;
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      sr_s_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      case (state_d)
        LOAD:    sr_s_q <= 2'b11;
        SHIFT:   sr_s_q <= dir_d ? 2'b10 : 2'b01;
        default: sr_s_q <= 2'b00;
      endcase
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
      shift_q <= (state_d == SHIFT);
    end
  end

  // Only sout/sr_r follow the register and sin combinationally; ready is masked while reset is held.
  assign io.sout       = shift_q & (dir_q ? io.sr_q[0] : io.sr_q[WIDTH-1]);
  assign io.sr_r       = shift_q & (rot_q ? io.sout : io.sin);
  assign io.sout_valid = shift_q;
  assign io.sr_s       = sr_s_q;
  assign io.sr_i       = data_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.cmd_ready  = ready_q & reset;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 8-bit shift register on the datapath side.
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus();
  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .io(bus));

  logic [W-1:0] reg_q = '0;
  assign bus.sr_q = reg_q;
  always @(posedge clk)
    case (bus.sr_s)
      2'b01:   reg_q <= {reg_q[W-2:0], bus.sr_r};
      2'b10:   reg_q <= {bus.sr_r, reg_q[W-1:1]};
      2'b11:   reg_q <= bus.sr_i;
      default: reg_q <= reg_q;
    endcase

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents a command in the current (IDLE) cycle; returns in cycle k+1.
  task automatic send(input logic ld, input logic dir, input logic [CW-1:0] len,
                      input logic [W-1:0] data, input logic rot, input logic keep);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_dir   = dir;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.cmd_rot   = rot;
`else
    if (rot) $display("rotate requested without SHIFT_SEQ_ROTATE_EN");
`endif
    step();
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  logic [W-1:0] pat;
  int n;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.cmd_rot   = 1'b0;
`endif
    bus.sin       = 1'b0;

    // Reset state
    #12;
    chk("rst_sr_s",  bus.sr_s, 2'b00);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_sr_i",  bus.sr_i, 8'h00);
    reset = 1'b1;
    #1;
    chk("rel_ready", bus.cmd_ready, 1);
    step();

    // Load 0xA5, shift left 8; a second command is held on cmd_valid throughout
    bus.sin = 1'b0;
    send(1'b1, 1'b0, 4'd8, 8'hA5, 1'b0, 1'b1);
    bus.cmd_load = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_len = 4'd2; bus.cmd_data = 8'h3C;
    chk("ld_sr_s",  bus.sr_s, 2'b11);
    chk("ld_sr_i",  bus.sr_i, 8'hA5);
    chk("ld_busy",  bus.busy, 1);
    chk("ld_ready", bus.cmd_ready, 0);
    pat = 8'hA5;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("l_sr_s", bus.sr_s, 2'b01);
      chk("l_vld",  bus.sout_valid, 1);
      chk("l_sout", bus.sout, pat[7-j]);
    end
    step();
    chk("l_done",  bus.done, 1);
    chk("l_sr_s0", bus.sr_s, 2'b00);
    chk("l_reg",   reg_q, 8'h00);
    chk("l_rdy0",  bus.cmd_ready, 0);
    step();
    chk("l_idle_rdy",  bus.cmd_ready, 1);
    chk("l_idle_done", bus.done, 0);
    // Held command now accepted from IDLE
    step();
    bus.cmd_valid = 1'b0;
    chk("b2b_sr_s", bus.sr_s, 2'b11);
    chk("b2b_sr_i", bus.sr_i, 8'h3C);
    step();
    chk("b2b_s1",   bus.sout, 0);
    chk("b2b_sr_s2", bus.sr_s, 2'b10);
    step();
    chk("b2b_s2",   bus.sout, 0);
    step();
    chk("b2b_done", bus.done, 1);
    chk("b2b_reg",  reg_q, 8'h0F);
    step();

    // Load 0x0F, shift right 3 with sin=1
    bus.sin = 1'b1;
    send(1'b1, 1'b1, 4'd3, 8'h0F, 1'b0, 1'b0);
    chk("r_ld", bus.sr_s, 2'b11);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("r_sr_s", bus.sr_s, 2'b10);
      chk("r_sr_r", bus.sr_r, 1);
      chk("r_sout", bus.sout, 1);
    end
    step();
    chk("r_done", bus.done, 1);
    chk("r_reg",  reg_q, 8'hE1);
    step();

    // Zero-length, no load
    send(1'b0, 1'b0, 4'd0, 8'h55, 1'b0, 1'b0);
    chk("z_done", bus.done, 1);
    chk("z_sr_s", bus.sr_s, 2'b00);
    chk("z_busy", bus.busy, 1);
    step();
    chk("z_ready", bus.cmd_ready, 1);
    chk("z_done0", bus.done, 0);

    // Clamp: len 12 yields 8 shifts, sin=1 fills the register
    send(1'b0, 1'b0, 4'd12, 8'h00, 1'b0, 1'b0);
    n = 0;
    for (int c = 0; c < 20 && !bus.done; c++) begin
      if (bus.sout_valid) n++;
      step();
    end
    chk("c_done",  bus.done, 1);
    chk("c_count", n, 8);
    chk("c_reg",   reg_q, 8'hFF);
    step();

`ifdef SHIFT_SEQ_ROTATE_EN
    bus.sin = 1'b0;
    send(1'b1, 1'b0, 4'd1, 8'h81, 1'b1, 1'b0);
    step();
    chk("rot_sout", bus.sout, 1);
    chk("rot_sr_r", bus.sr_r, 1);
    step();
    chk("rot_done", bus.done, 1);
    chk("rot_reg",  reg_q, 8'h03);
    step();
`endif

    // Reset during the 3rd SHIFT cycle
    bus.sin = 1'b0;
    send(1'b1, 1'b0, 4'd8, 8'hA5, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("m_pre_vld", bus.sout_valid, 1);
    reset = 1'b0;
    #1;
    chk("m_sr_s",  bus.sr_s, 2'b00);
    chk("m_busy",  bus.busy, 0);
    chk("m_ready", bus.cmd_ready, 0);
    chk("m_vld",   bus.sout_valid, 0);
    chk("m_sr_i",  bus.sr_i, 8'h00);
    step();
    chk("m_nodone", bus.done, 0);
    reset = 1'b1;
    step();
    chk("m_ready1", bus.cmd_ready, 1);
    chk("m_done1",  bus.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
